// File: rtl/mem_stage.sv
// Memory-access stage: issues data-memory requests for loads/stores, aligns
// byte lanes, extends load data and emits one registered writeback record.
module mem_stage #(
  parameter int XLEN = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [6:0]          in_opcode,
  input  logic [2:0]          in_funct3,
  input  logic [XLEN-1:0]     in_alu_out,
  input  logic [XLEN-1:0]     in_store_data,
  input  logic [4:0]          in_rd,
  input  logic                in_reg_write,
  output logic                stall_out,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [XLEN-1:0]     dmem_addr,
  output logic [XLEN-1:0]     dmem_wdata,
  output logic [XLEN/8-1:0]   dmem_wstrb,
  input  logic                dmem_ready,
  input  logic                dmem_rvalid,
  input  logic [XLEN-1:0]     dmem_rdata,
  output logic                wb_valid,
  output logic [4:0]          wb_rd,
  output logic [XLEN-1:0]     wb_data,
  output logic                wb_reg_write,
  output logic                misalign_exc
);

  localparam int NB = XLEN / 8;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t      state;
  logic [2:0]  funct3_p0;
  logic [1:0]  lane_p0;
  logic [4:0]  rd_p0;
  logic        reg_write_p0;
  logic        is_store_p0;

  logic is_load, is_store, legal, misaligned, mem_bad, mem_ok;

  function automatic logic [XLEN-1:0] extend_load(input logic [XLEN-1:0] word,
                                                  input logic [2:0] f3,
                                                  input logic [1:0] lane);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [XLEN-1:0]    res;
    b = word[8*lane +: 8];
    h = word[16*lane[1] +: 16];
    case (f3)
      3'b000:  res = XLEN'(b);
      3'b001:  res = XLEN'(h);
      3'b100:  res = XLEN'($unsigned(b));
      3'b101:  res = XLEN'($unsigned(h));
      default: res = word;
    endcase
    return res;
  endfunction

  function automatic logic [XLEN-1:0] store_wdata(input logic [2:0] f3,
                                                  input logic [XLEN-1:0] data);
    logic [XLEN-1:0] res;
    case (f3[1:0])
      2'b00:   res = {NB{data[7:0]}};
      2'b01:   res = {(NB/2){data[15:0]}};
      default: res = data;
    endcase
    return res;
  endfunction

  function automatic logic [NB-1:0] store_wstrb(input logic [2:0] f3,
                                                input logic [1:0] lane);
    logic [NB-1:0] res;
    case (f3[1:0])
      2'b00:   res = NB'(1) << lane;
      2'b01:   res = NB'(3) << {lane[1], 1'b0};
      default: res = '1;
    endcase
    return res;
  endfunction

  // Access classification for the instruction presented in IDLE
  always_comb begin
    is_load    = (in_opcode == OP_LOAD);
    is_store   = (in_opcode == OP_STORE);
    legal      = 1'b1;
    if (is_load)
      legal = (in_funct3 == 3'b000) || (in_funct3 == 3'b001) || (in_funct3 == 3'b010) ||
              (in_funct3 == 3'b100) || (in_funct3 == 3'b101);
    else if (is_store)
      legal = (in_funct3 <= 3'b010);
    misaligned = ((in_funct3[1:0] == 2'b01) && in_alu_out[0]) ||
                 ((in_funct3[1:0] == 2'b10) && (in_alu_out[1:0] != 2'b00));
    mem_bad    = (is_load || is_store) && (!legal || misaligned);
    mem_ok     = (is_load || is_store) && !mem_bad;
  end

  // Stall is dropped in every completing cycle so upstream advances on that edge
  always_comb begin
    stall_out = 1'b0;
    case (state)
      IDLE:    stall_out = in_valid && mem_ok;
      REQ:     stall_out = !(dmem_ready && is_store_p0);
      WAIT:    stall_out = !dmem_rvalid;
      default: stall_out = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_wstrb   <= '0;
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      misalign_exc <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
    end else begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      misalign_exc <= 1'b0;
      case (state)
        // IDLE -> capture stage: accept a memory op or retire directly
        IDLE: begin
          if (in_valid) begin
            if (mem_ok) begin
              funct3_p0    <= in_funct3;
              lane_p0      <= in_alu_out[1:0];
              rd_p0        <= in_rd;
              reg_write_p0 <= in_reg_write;
              is_store_p0  <= is_store;
              dmem_req     <= 1'b1;
              dmem_we      <= is_store;
              dmem_addr    <= {in_alu_out[XLEN-1:2], 2'b00};
              dmem_wdata   <= store_wdata(in_funct3, in_store_data);
              dmem_wstrb   <= is_store ? store_wstrb(in_funct3, in_alu_out[1:0]) : '0;
              state        <= REQ;
            end else begin
              wb_valid     <= 1'b1;
              wb_rd        <= in_rd;
              wb_data      <= in_alu_out;
              wb_reg_write <= in_reg_write && !mem_bad;
              misalign_exc <= mem_bad;
            end
          end
        end
        // REQ stage: request held stable until the memory accepts it
        REQ: begin
          if (dmem_ready) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_wstrb <= '0;
            if (is_store_p0) begin
              wb_valid <= 1'b1;
              wb_rd    <= rd_p0;
              state    <= IDLE;
            end else begin
              state    <= WAIT;
            end
          end
        end
        // WAIT stage: load data returns and is lane-extracted into writeback
        WAIT: begin
          if (dmem_rvalid) begin
            wb_valid     <= 1'b1;
            wb_rd        <= rd_p0;
            wb_reg_write <= reg_write_p0;
            wb_data      <= extend_load(dmem_rdata, funct3_p0, lane_p0);
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized
// instruction streams checked against an arithmetic reference model.
module tb_mem_stage;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [31:0] in_alu_out;
  logic [31:0] in_store_data;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic        stall_out;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ready;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_reg_write;
  logic        misalign_exc;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_stage #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_opcode(in_opcode),
    .in_funct3(in_funct3), .in_alu_out(in_alu_out), .in_store_data(in_store_data),
    .in_rd(in_rd), .in_reg_write(in_reg_write), .stall_out(stall_out),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_ready(dmem_ready),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_data(wb_data), .wb_reg_write(wb_reg_write),
    .misalign_exc(misalign_exc)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_bad(input logic [6:0] op, input logic [2:0] f3,
                                   input logic [31:0] a);
    int  size;
    bit  ok;
    size = 1 << (int'(f3) % 4);
    if (op == OP_LOAD)       ok = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    else if (op == OP_STORE) ok = (f3 <= 3'd2);
    else return 1'b0;
    return !ok || ((a % size) != 0);
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd_word);
    int lane, b, h;
    lane = int'(a % 4);
    b = int'((rd_word >> (8 * lane)) & 32'hFF);
    h = int'((rd_word >> (16 * (lane / 2))) & 32'hFFFF);
    case (f3)
      3'd0:    return (b >= 128)   ? 32'(b - 256)   : 32'(b);
      3'd1:    return (h >= 32768) ? 32'(h - 65536) : 32'(h);
      3'd4:    return 32'(b);
      3'd5:    return 32'(h);
      default: return rd_word;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'd0:    return (d & 32'hFF) * 32'h01010101;
      3'd1:    return (d & 32'hFFFF) * 32'h00010001;
      default: return d;
    endcase
  endfunction

  function automatic logic [3:0] model_wstrb(input logic [2:0] f3, input logic [31:0] a);
    case (f3)
      3'd0:    return 4'(1 << (a % 4));
      3'd1:    return 4'(3 << (a % 4));
      default: return 4'hF;
    endcase
  endfunction

  // One instruction from presentation until its writeback record appears
  task automatic do_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] data, input logic [4:0] rd, input bit rw,
                       input int ready_dly, input int rvalid_dly, input logic [31:0] rdata);
    bit is_mem, is_st, bad;
    @(negedge clk);
    in_valid = 1'b1; in_opcode = op; in_funct3 = f3; in_alu_out = addr;
    in_store_data = data; in_rd = rd; in_reg_write = rw;
    dmem_ready = 1'b0; dmem_rvalid = 1'($urandom % 2); dmem_rdata = $urandom;
    is_mem = (op == OP_LOAD) || (op == OP_STORE);
    is_st  = (op == OP_STORE);
    bad    = model_bad(op, f3, addr);
    #1;
    if (!is_mem || bad) begin
      chk("stall_direct", 32'(stall_out), 32'd0);
      @(posedge clk); #1;
      chk("wb_valid_direct", 32'(wb_valid), 32'd1);
      chk("misalign_exc", 32'(misalign_exc), 32'(bad));
      chk("wb_reg_write_direct", 32'(wb_reg_write), 32'(rw && !bad));
      chk("no_req_direct", 32'(dmem_req), 32'd0);
      if (!bad) begin
        chk("wb_data_alu", wb_data, addr);
        chk("wb_rd_alu", 32'(wb_rd), 32'(rd));
      end
    end else begin
      chk("stall_accept", 32'(stall_out), 32'd1);
      @(posedge clk);
      for (int k = 0; k <= ready_dly; k++) begin
        @(negedge clk);
        dmem_ready  = (k == ready_dly);
        dmem_rvalid = 1'($urandom % 2);
        #1;
        chk("req_high", 32'(dmem_req), 32'd1);
        chk("req_addr", dmem_addr, addr & 32'hFFFF_FFFC);
        chk("req_we", 32'(dmem_we), 32'(is_st));
        chk("req_wstrb", 32'(dmem_wstrb), is_st ? 32'(model_wstrb(f3, addr)) : 32'd0);
        if (is_st) chk("req_wdata", dmem_wdata, model_wdata(f3, data));
        chk("wb_quiet_req", 32'(wb_valid), 32'd0);
        chk("stall_req", 32'(stall_out), 32'(!(is_st && dmem_ready)));
        @(posedge clk);
      end
      if (is_st) begin
        #1;
        chk("wb_valid_store", 32'(wb_valid), 32'd1);
        chk("wb_reg_write_store", 32'(wb_reg_write), 32'd0);
        chk("misalign_store", 32'(misalign_exc), 32'd0);
      end else begin
        for (int j = 0; j <= rvalid_dly; j++) begin
          @(negedge clk);
          dmem_ready  = 1'($urandom % 2);
          dmem_rvalid = (j == rvalid_dly);
          dmem_rdata  = (j == rvalid_dly) ? rdata : $urandom;
          #1;
          chk("req_low_wait", 32'(dmem_req), 32'd0);
          chk("stall_wait", 32'(stall_out), 32'(!dmem_rvalid));
          chk("wb_quiet_wait", 32'(wb_valid), 32'd0);
          @(posedge clk);
        end
        #1;
        chk("wb_valid_load", 32'(wb_valid), 32'd1);
        chk("wb_data_load", wb_data, model_load(f3, addr, rdata));
        chk("wb_rd_load", 32'(wb_rd), 32'(rd));
        chk("wb_reg_write_load", 32'(wb_reg_write), 32'(rw));
        chk("misalign_load", 32'(misalign_exc), 32'd0);
      end
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    in_valid = 1'b0; dmem_ready = 1'($urandom % 2); dmem_rvalid = 1'($urandom % 2);
    dmem_rdata = $urandom;
    #1;
    chk("stall_idle", 32'(stall_out), 32'd0);
    @(posedge clk); #1;
    chk("wb_quiet_idle", 32'(wb_valid), 32'd0);
    chk("req_idle", 32'(dmem_req), 32'd0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_opcode = '0; in_funct3 = '0; in_alu_out = '0;
    in_store_data = '0; in_rd = '0; in_reg_write = 1'b0;
    dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_reg_write", 32'(wb_reg_write), 32'd0);
    chk("rst_misalign", 32'(misalign_exc), 32'd0);
    chk("rst_wb_rd", 32'(wb_rd), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_dmem_req", 32'(dmem_req), 32'd0);
    @(negedge clk); reset = 1'b0;

    do_op(7'b0110011, 3'd0, 32'h5, 32'h0, 5'd3, 1'b1, 0, 0, 32'h0);
    do_op(OP_LOAD, 3'd0, 32'h103, 32'h0, 5'd5, 1'b1, 0, 0, 32'h80AABBCC);
    do_op(OP_LOAD, 3'd4, 32'h103, 32'h0, 5'd6, 1'b1, 0, 0, 32'h80AABBCC);
    do_op(OP_STORE, 3'd1, 32'h202, 32'h1234ABCD, 5'd0, 1'b0, 3, 0, 32'h0);
    do_op(OP_LOAD, 3'd2, 32'h301, 32'h0, 5'd7, 1'b1, 0, 0, 32'h0);
    do_op(OP_LOAD, 3'd2, 32'h40, 32'h0, 5'd8, 1'b1, 0, 0, 32'hDEADBEEF);
    do_op(7'b0010011, 3'd0, 32'h7, 32'h0, 5'd9, 1'b1, 0, 0, 32'h0);
    do_op(OP_LOAD, 3'd1, 32'h82, 32'h0, 5'd10, 1'b1, 1, 2, 32'h9876_0011);
    do_op(OP_STORE, 3'd3, 32'h80, 32'h0, 5'd0, 1'b0, 0, 0, 32'h0);
    idle_cycle();

    // Reset while a load waits for its data; the late rvalid must be dropped
    @(negedge clk);
    in_valid = 1'b1; in_opcode = OP_LOAD; in_funct3 = 3'd2; in_alu_out = 32'h500;
    in_rd = 5'd11; in_reg_write = 1'b1; dmem_ready = 1'b0; dmem_rvalid = 1'b0;
    @(negedge clk); dmem_ready = 1'b1;
    @(negedge clk); dmem_ready = 1'b0; reset = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_wait_req", 32'(dmem_req), 32'd0);
    chk("rst_wait_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wait_wb_data", wb_data, 32'd0);
    @(negedge clk); reset = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h11;
    #1;
    chk("rst_wait_stall", 32'(stall_out), 32'd0);
    @(posedge clk); #1;
    chk("rst_late_rvalid", 32'(wb_valid), 32'd0);
    chk("rst_late_req", 32'(dmem_req), 32'd0);

    for (int i = 0; i < 200; i++) begin
      int          kind;
      logic [6:0]  op;
      kind = int'($urandom % 3);
      op   = (kind == 0) ? (($urandom % 2) ? 7'b0110011 : 7'b0010011) :
             (kind == 1) ? OP_LOAD : OP_STORE;
      do_op(op, 3'($urandom % 8), $urandom, $urandom, 5'($urandom), 1'($urandom % 2),
            int'($urandom % 4), int'($urandom % 4), $urandom);
      if (($urandom % 8) == 0) idle_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
